pulse_encoder_banked: RTL and testbench

PULSE_ENCODER_BANKED -- requirements
Module: pulse_encoder_banked

---
 rtl/pulse_encoder_banked.sv | 121 ++++++++++++
 tb/tb_pulse_encoder_banked.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_encoder_banked.sv
// Maps random bytes to one-hot pulse channels and packs the per-cycle state symbols into banked words.
// Optional macro BANK_MARKER_EN replaces each bank-final word with the running bank count.
module pulse_encoder_banked #(
  parameter int unsigned NUM_CH  = 6,
  parameter int unsigned STATE_W = 3,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned BANK_AW = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable_signal,
  input  logic [7:0]                  i_data,
  input  logic [NUM_CH*8-1:0]         thr,
  output logic [NUM_CH-1:0]           pulses,
  output logic [WORD_W-1:0]           SD_data,
  output logic [ADDR_W-1:0]           adr_reg,
  output logic [ADDR_W-BANK_AW-1:0]   cpy_en,
  output logic                        save_data_pulse
);

  localparam int unsigned SPW    = WORD_W / STATE_W;
  localparam int unsigned SLOT_W = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int unsigned BANK_W = ADDR_W - BANK_AW;
  localparam logic [STATE_W-1:0] VACUUM    = '1;
  localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(SPW - 1);

  logic [NUM_CH-1:0]  r_pulses;
  logic [WORD_W-1:0]  r_sd;
  logic [WORD_W-1:0]  r_buf;
  logic [ADDR_W-1:0]  r_adr;
  logic [BANK_W-1:0]  r_cpy;
  logic               r_save;
  logic [SLOT_W-1:0]  r_slot;
  logic [31:0]        r_bank_count;

  logic [STATE_W-1:0] w_state;
  logic [NUM_CH-1:0]  w_onehot;
  logic [WORD_W-1:0]  w_word;
  logic [WORD_W-1:0]  w_out;
  logic [BANK_AW-1:0] w_adr_low;
  logic               w_bank_final;
  logic               w_last;

  // Lowest channel whose threshold exceeds the sample wins; none matching gives the vacuum symbol.
  always_comb begin
    w_state  = VACUUM;
    w_onehot = '0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (i_data < thr[8*k +: 8]) begin
        w_state     = STATE_W'(k + 1);
        w_onehot    = '0;
        w_onehot[k] = 1'b1;
      end
    end
  end

  // Word under assembly including this cycle's symbol; slot 0 starts from a clean buffer.
  always_comb begin
    w_word = (r_slot == '0) ? '0 : r_buf;
    for (int s = 0; s < int'(SPW); s++) begin
      if (r_slot == SLOT_W'(s)) begin
        w_word[STATE_W*s +: STATE_W] = w_state;
      end
    end
  end

  // Address the finishing word carries, used to spot the last word of a bank.
  always_comb begin
    w_adr_low    = (r_slot == '0) ? (r_adr[BANK_AW-1:0] + BANK_AW'(1)) : r_adr[BANK_AW-1:0];
    w_bank_final = &w_adr_low;
    w_last       = (r_slot == LAST_SLOT);
`ifdef BANK_MARKER_EN
    w_out        = w_bank_final ? WORD_W'(r_bank_count) : w_word;
`else
    w_out        = w_word;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pulses     <= '0;
      r_sd         <= '0;
      r_buf        <= '0;
      r_adr        <= '0;
      r_cpy        <= '0;
      r_save       <= 1'b0;
      r_slot       <= '0;
      r_bank_count <= '0;
    end else begin
      r_save <= 1'b0;
      if (enable_signal) begin
        r_pulses <= w_onehot;
        r_buf    <= w_word;
        if (r_slot == '0) begin
          r_adr <= r_adr + ADDR_W'(1);
        end
        if (w_last) begin
          r_slot <= '0;
          r_sd   <= w_out;
          r_save <= 1'b1;
          if (w_bank_final) begin
            r_cpy        <= r_cpy + BANK_W'(1);
            r_bank_count <= r_bank_count + 32'd1;
          end
        end else begin
          r_slot <= r_slot + SLOT_W'(1);
        end
      end else begin
        r_pulses <= '0;
      end
    end
  end

  assign pulses          = r_pulses;
  assign SD_data         = r_sd;
  assign adr_reg         = r_adr;
  assign cpy_en          = r_cpy;
  assign save_data_pulse = r_save;

endmodule

// File: tb/tb_pulse_encoder_banked.sv
// Directed bench for pulse_encoder_banked: a behavioural model queues expected words, checked on each strobe.
// A second instance covers the narrow-symbol configuration (2-bit symbols, 16-bit words).
module tb_pulse_encoder_banked;

  localparam int unsigned NCH = 6;
  localparam int unsigned SW  = 3;
  localparam int unsigned WW  = 32;
  localparam int unsigned AW  = 7;
  localparam int unsigned BAW = 5;
  localparam int          SPW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable_signal;
  logic [7:0]      i_data;
  logic [NCH*8-1:0] thr;
  logic [NCH-1:0]  pulses;
  logic [WW-1:0]   SD_data;
  logic [AW-1:0]   adr_reg;
  logic [AW-BAW-1:0] cpy_en;
  logic            save_data_pulse;

  logic [15:0]     thr2;
  logic [1:0]      pulses2;
  logic [15:0]     sd2;
  logic [AW-1:0]   adr2;
  logic [AW-BAW-1:0] cpy2;
  logic            save2;

  always #5 clk = ~clk;

  pulse_encoder_banked #(.NUM_CH(NCH), .STATE_W(SW), .WORD_W(WW), .ADDR_W(AW), .BANK_AW(BAW)) dut (
    .clk(clk), .rst(rst), .enable_signal(enable_signal), .i_data(i_data), .thr(thr),
    .pulses(pulses), .SD_data(SD_data), .adr_reg(adr_reg), .cpy_en(cpy_en),
    .save_data_pulse(save_data_pulse));

  pulse_encoder_banked #(.NUM_CH(2), .STATE_W(2), .WORD_W(16), .ADDR_W(AW), .BANK_AW(BAW)) dut2 (
    .clk(clk), .rst(rst), .enable_signal(enable_signal), .i_data(i_data), .thr(thr2),
    .pulses(pulses2), .SD_data(sd2), .adr_reg(adr2), .cpy_en(cpy2),
    .save_data_pulse(save2));

  typedef struct packed {
    logic [31:0]     sd;
    logic [AW-1:0]   adr;
    logic [AW-BAW-1:0] cpy;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          n_strobes = 0;
  int          m_slot;
  logic [31:0] m_buf, m_last, m_bc;
  logic [AW-1:0] m_adr;
  logic [AW-BAW-1:0] m_cpy;
  logic [NCH-1:0] exp_pulses;
  logic        exp_strobe;

  localparam logic [47:0] THR_DEF = {8'd255, 8'd229, 8'd208, 8'd194, 8'd180, 8'd102};

  function automatic logic [2:0] map_sym(input logic [7:0] d, input logic [47:0] t);
    for (int k = 0; k < 6; k++) begin
      if (d < t[8*k +: 8]) return 3'(k + 1);
    end
    return 3'b111;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_slot = 0; m_buf = '0; m_last = '0; m_bc = '0; m_adr = '0; m_cpy = '0;
    exp_pulses = '0; exp_strobe = 1'b0;
    sb.delete();
  endtask

  // Called at a falling edge: drives one cycle, advances the model, checks after the rising edge.
  task automatic step(input logic en, input logic [7:0] d);
    logic [2:0] sym;
    exp_t       e;
    enable_signal = en;
    i_data        = d;
    exp_strobe    = 1'b0;
    if (en) begin
      sym        = map_sym(d, thr);
      exp_pulses = (sym == 3'b111) ? '0 : (NCH'(1) << (sym - 3'd1));
      if (m_slot == 0) begin
        m_buf = '0;
        m_adr = m_adr + 1'b1;
      end
      m_buf[3*m_slot +: 3] = sym;
      if (m_slot == SPW - 1) begin
        m_slot     = 0;
        exp_strobe = 1'b1;
        m_last     = m_buf;
        if (&m_adr[BAW-1:0]) begin
`ifdef BANK_MARKER_EN
          m_last = m_bc;
`endif
          m_cpy = m_cpy + 1'b1;
          m_bc  = m_bc + 32'd1;
        end
        e.sd = m_last; e.adr = m_adr; e.cpy = m_cpy;
        sb.push_back(e);
      end else begin
        m_slot++;
      end
    end else begin
      exp_pulses = '0;
    end
    @(posedge clk);
    #1;
    chk("pulses", 64'(pulses), 64'(exp_pulses));
    chk("strobe", 64'(save_data_pulse), 64'(exp_strobe));
    chk("adr", 64'(adr_reg), 64'(m_adr));
    chk("cpy", 64'(cpy_en), 64'(m_cpy));
    chk("sd_hold", 64'(SD_data), 64'(m_last));
    if (save_data_pulse === 1'b1) begin
      n_strobes++;
      chk("sb_avail", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_sd", 64'(SD_data), 64'(e.sd));
        chk("sb_adr", 64'(adr_reg), 64'(e.adr));
        chk("sb_cpy", 64'(cpy_en), 64'(e.cpy));
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    enable_signal = 1'b1;
    i_data        = 8'($urandom);
    @(posedge clk);
    #1;
    chk("rst_pulses", 64'(pulses), 64'd0);
    chk("rst_sd", 64'(SD_data), 64'd0);
    chk("rst_adr", 64'(adr_reg), 64'd0);
    chk("rst_cpy", 64'(cpy_en), 64'd0);
    chk("rst_strobe", 64'(save_data_pulse), 64'd0);
    chk("rst_sd2", 64'(sd2), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; enable_signal = 1'b0; i_data = '0;
    thr = THR_DEF; thr2 = {8'd200, 8'd100};
    model_reset();
    @(negedge clk);
    do_reset();

    // 120 falls between the first two thresholds: channel 1, state 2 in every slot.
    for (int i = 0; i < SPW; i++) begin
      step(1'b1, 8'd120);
      if (i == 0) chk("t1_pulses", 64'(pulses), 64'h02);
    end
    chk("t1_sd", 64'(SD_data), 64'h12492492);
    chk("t1_adr", 64'(adr_reg), 64'd1);
    chk("t1_strobe", 64'(save_data_pulse), 64'd1);
    step(1'b0, 8'd120);
    chk("t1_strobe_off", 64'(save_data_pulse), 64'd0);

    for (int i = 0; i < SPW; i++) step(1'b1, 8'd60);
    chk("t2_sd", 64'(SD_data), 64'h09249249);

    thr = '0;
    for (int i = 0; i < SPW; i++) step(1'b1, 8'($urandom));
    chk("vac_sd", 64'(SD_data), 64'h3FFFFFFF);
    chk("vac_pulses", 64'(pulses), 64'd0);

    // Alternating enable: 20 samples make exactly two words.
    thr = THR_DEF;
    do_reset();
    n_strobes = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom));
      step(1'b0, 8'($urandom));
    end
    chk("toggle_strobes", 64'(n_strobes), 64'd2);

    // Reset in the middle of a word discards it.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
    do_reset();
    n_strobes = 0;
    for (int i = 0; i < SPW - 1; i++) step(1'b1, 8'($urandom));
    chk("mid_no_strobe", 64'(n_strobes), 64'd0);
    step(1'b1, 8'($urandom));
    chk("mid_strobe", 64'(save_data_pulse), 64'd1);
    chk("mid_adr", 64'(adr_reg), 64'd1);

    // Threshold change mid-word applies from the next sample only.
    thr = {8'd250, 8'd240, 8'd200, 8'd150, 8'd100, 8'd50};
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom));
    thr = {8'd255, 8'd128, 8'd96, 8'd64, 8'd32, 8'd16};
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom));

    // Bank boundaries at addresses 31, 63, 95, 127.
    thr = THR_DEF;
    do_reset();
    for (int w = 1; w <= 127; w++) begin
      for (int s = 0; s < SPW; s++) begin
        if ($urandom_range(0, 7) == 0) step(1'b0, 8'($urandom));
        step(1'b1, (w == 31 || w == 127) ? 8'd120 : 8'($urandom));
      end
      if (w == 31) begin
        chk("bank1_cpy", 64'(cpy_en), 64'd1);
`ifdef BANK_MARKER_EN
        chk("bank1_marker", 64'(SD_data), 64'd0);
`else
        chk("bank1_data", 64'(SD_data), 64'h12492492);
`endif
      end
    end
    chk("bank4_cpy", 64'(cpy_en), 64'd0);
    chk("bank4_adr", 64'(adr_reg), 64'd127);
`ifdef BANK_MARKER_EN
    chk("bank4_marker", 64'(SD_data), 64'd3);
`else
    chk("bank4_data", 64'(SD_data), 64'h12492492);
`endif

    // Narrow configuration: eight slots of state 1.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'd0);
      if (i == 0) chk("n_pulses", 64'(pulses2), 64'd1);
      if (i < 7) chk("n_no_strobe", 64'(save2), 64'd0);
    end
    chk("n_strobe", 64'(save2), 64'd1);
    chk("n_sd", 64'(sd2), 64'h5555);
    chk("n_adr", 64'(adr2), 64'd1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
